// File: rtl/frame_slot_pkg.sv
// frame_slot_pkg: shared sizing and slot-state encoding for the frame slot scheduler
package frame_slot_pkg;
    localparam int NUM_SLOTS = 16;
    localparam int SLOT_W = 4;
    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2,
        READING = 2'd3
    } slot_state_t;
endpackage

// File: rtl/slot_ready_fifo.sv
// slot_ready_fifo: commit-ordered queue of READY slot indices with prefetched head and occupancy count
module slot_ready_fifo
    import frame_slot_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [SLOT_W-1:0] push_slot,
    input  logic              pop,
    output logic              vld,
    output logic [SLOT_W-1:0] head,
    output logic [SLOT_W:0]   count
);
    logic [SLOT_W-1:0] mem [NUM_SLOTS];
    logic [SLOT_W-1:0] wr_ptr;
    logic [SLOT_W-1:0] rd_ptr;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= push_slot;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + SLOT_W'(push);
            rd_ptr <= rd_ptr + SLOT_W'(pop);
            count  <= count + (SLOT_W+1)'(push) - (SLOT_W+1)'(pop);
        end
    assign vld  = count != '0;
    assign head = vld ? mem[rd_ptr] : '0;
endmodule

// File: rtl/frame_slot_scheduler.sv
// frame_slot_scheduler: grants free frame slots to two producers, queues committed slots for a consumer
module frame_slot_scheduler #(
    parameter int NUM_SLOTS   = frame_slot_pkg::NUM_SLOTS,
    parameter int DROP_OLDEST = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      req,
    output logic [1:0]                      gnt,
    output logic [frame_slot_pkg::SLOT_W-1:0] gnt_slot,
    input  logic                            commit_en,
    input  logic [frame_slot_pkg::SLOT_W-1:0] commit_slot,
    output logic                            rd_vld,
    output logic [frame_slot_pkg::SLOT_W-1:0] rd_slot,
    input  logic                            rd_en,
    input  logic                            release_en,
    input  logic [frame_slot_pkg::SLOT_W-1:0] release_slot,
    output logic [frame_slot_pkg::SLOT_W:0]   free_cnt,
    output logic                            drop_pulse,
    output logic                            err_pulse
);
    import frame_slot_pkg::*;
    slot_state_t       state     [NUM_SLOTS];
    slot_state_t       state_nxt [NUM_SLOTS];
    logic [SLOT_W:0]   ready_cnt;
    logic [SLOT_W:0]   free_now;
    logic [SLOT_W-1:0] low_free;
    logic [1:0]        elig;
    logic              free_any, pick, pick_vld, do_gnt, do_rd, do_drop;
    logic              commit_ok, release_ok, ptr;
    // a requester granted last cycle sits out this one
    assign elig     = req & ~gnt;
    assign pick_vld = |elig;
    assign pick     = ptr ? elig[1] : ~elig[0];
    assign do_rd    = rd_en & rd_vld;
    assign do_gnt   = pick_vld & free_any;
    assign do_drop  = (DROP_OLDEST != 0) && pick_vld && !free_any && ready_cnt >= 2 && !do_rd;
    assign commit_ok  = commit_en && state[commit_slot] == WRITING;
    assign release_ok = release_en && state[release_slot] == READING;
    always_comb begin
        free_any = 1'b0;
        low_free = '0;
        free_now = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (state[i] == FREE) begin
                free_any = 1'b1;
                low_free = SLOT_W'(i);
                free_now = free_now + 1'b1;
            end
        state_nxt = state;
        // every transition below targets a slot in a distinct state, so no two collide
        if (do_gnt) state_nxt[low_free] = WRITING;
        if (commit_ok) state_nxt[commit_slot] = READY;
        if (do_rd) state_nxt[rd_slot] = READING;
        if (do_drop) state_nxt[rd_slot] = FREE;
        if (release_ok) state_nxt[release_slot] = FREE;
    end
    slot_ready_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (commit_ok),
        .push_slot (commit_slot),
        .pop       (do_rd | do_drop),
        .vld       (rd_vld),
        .head      (rd_slot),
        .count     (ready_cnt)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= '{default: FREE};
            gnt        <= '0;
            gnt_slot   <= '0;
            ptr        <= 1'b0;
            free_cnt   <= (SLOT_W+1)'(NUM_SLOTS);
            drop_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            state      <= state_nxt;
            gnt        <= do_gnt ? (pick ? 2'b10 : 2'b01) : 2'b00;
            gnt_slot   <= do_gnt ? low_free : '0;
            if (do_gnt) ptr <= ~pick;
            free_cnt   <= free_now;
            drop_pulse <= do_drop;
            err_pulse  <= (commit_en & ~commit_ok) | (release_en & ~release_ok);
        end
endmodule

// File: tb/tb_frame_slot_scheduler.sv
// tb_frame_slot_scheduler: directed checks of grant, queue, drop, error and reset behaviour
module tb_frame_slot_scheduler;
    logic       clk = 1'b0, rst = 1'b1;
    logic [1:0] req = '0, gnt;
    logic [3:0] gnt_slot, commit_slot = '0, rd_slot, release_slot = '0;
    logic       commit_en = 1'b0, rd_vld, rd_en = 1'b0, release_en = 1'b0;
    logic [4:0] free_cnt;
    logic       drop_pulse, err_pulse;
    int         n_run = 0, n_fail = 0;

    frame_slot_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_slot(gnt_slot),
        .commit_en(commit_en), .commit_slot(commit_slot), .rd_vld(rd_vld), .rd_slot(rd_slot),
        .rd_en(rd_en), .release_en(release_en), .release_slot(release_slot),
        .free_cnt(free_cnt), .drop_pulse(drop_pulse), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; commit_en = 0; rd_en = 0; release_en = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // reset values
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_gnt_slot", 32'(gnt_slot), 0);
        chk("rst_rd_vld", 32'(rd_vld), 0);
        chk("rst_rd_slot", 32'(rd_slot), 0);
        chk("rst_free_cnt", 32'(free_cnt), 16);
        chk("rst_drop", 32'(drop_pulse), 0);
        chk("rst_err", 32'(err_pulse), 0);
        rst = 1'b0;
        // single grant, free_cnt lags one cycle
        req = 2'b01;
        tick();
        chk("g1_gnt", 32'(gnt), 1);
        chk("g1_slot", 32'(gnt_slot), 0);
        chk("g1_free_lag", 32'(free_cnt), 16);
        req = 2'b00;
        tick();
        chk("g1_gnt_off", 32'(gnt), 0);
        chk("g1_free", 32'(free_cnt), 15);
        // round robin with both requesting
        do_reset();
        req = 2'b11;
        tick();
        chk("rr0_gnt", 32'(gnt), 1);
        chk("rr0_slot", 32'(gnt_slot), 0);
        tick();
        chk("rr1_gnt", 32'(gnt), 2);
        chk("rr1_slot", 32'(gnt_slot), 1);
        tick();
        chk("rr2_gnt", 32'(gnt), 1);
        chk("rr2_slot", 32'(gnt_slot), 2);
        req = 2'b00;
        tick();
        chk("rr_idle", 32'(gnt), 0);
        chk("rr_free", 32'(free_cnt), 13);
        // FIFO ordering: commit 3, 1, 2
        req = 2'b01;
        tick();
        chk("q_gnt_slot3", 32'(gnt_slot), 3);
        req = 2'b00; commit_en = 1; commit_slot = 3;
        tick();
        chk("q_vld", 32'(rd_vld), 1);
        chk("q_head3", 32'(rd_slot), 3);
        commit_slot = 1;
        tick();
        commit_slot = 2;
        tick();
        commit_en = 0;
        chk("q_head_kept", 32'(rd_slot), 3);
        rd_en = 1;
        tick();
        chk("q_rd1", 32'(rd_slot), 1);
        tick();
        chk("q_rd2", 32'(rd_slot), 2);
        tick();
        chk("q_empty_vld", 32'(rd_vld), 0);
        chk("q_empty_slot", 32'(rd_slot), 0);
        rd_en = 0;
        // simultaneous release of 3 and commit of 0
        release_en = 1; release_slot = 3; commit_en = 1; commit_slot = 0;
        tick();
        chk("cr_vld", 32'(rd_vld), 1);
        chk("cr_head0", 32'(rd_slot), 0);
        chk("cr_err", 32'(err_pulse), 0);
        commit_en = 0; release_slot = 1; rd_en = 1;
        tick();
        chk("cr_rd_vld", 32'(rd_vld), 0);
        rd_en = 0; release_slot = 2;
        tick();
        release_slot = 0;
        tick();
        release_en = 0;
        tick();
        chk("rel_free16", 32'(free_cnt), 16);
        chk("rel_err", 32'(err_pulse), 0);
        // illegal release and commit
        release_en = 1; release_slot = 5;
        tick();
        chk("err_rel", 32'(err_pulse), 1);
        release_en = 0; commit_en = 1; commit_slot = 7;
        tick();
        chk("err_commit", 32'(err_pulse), 1);
        commit_en = 0;
        tick();
        chk("err_clear", 32'(err_pulse), 0);
        chk("err_free", 32'(free_cnt), 16);
        chk("err_rd_vld", 32'(rd_vld), 0);
        // fill all 16 slots, commit in reverse order
        do_reset();
        req = 2'b11;
        repeat (16) tick();
        chk("fill_gnt", 32'(gnt), 2);
        chk("fill_slot", 32'(gnt_slot), 15);
        req = 2'b00;
        tick();
        chk("fill_free0", 32'(free_cnt), 0);
        commit_en = 1;
        for (int i = 0; i < 16; i++) begin
            commit_slot = 4'(15 - i);
            tick();
        end
        commit_en = 0;
        chk("fill_head", 32'(rd_slot), 15);
        chk("fill_err", 32'(err_pulse), 0);
        // starved request reclaims the oldest READY slot
        req = 2'b01;
        tick();
        chk("drop_pulse", 32'(drop_pulse), 1);
        chk("drop_nognt", 32'(gnt), 0);
        chk("drop_head", 32'(rd_slot), 14);
        tick();
        chk("drop_gnt", 32'(gnt), 1);
        chk("drop_gnt_slot", 32'(gnt_slot), 15);
        chk("drop_once", 32'(drop_pulse), 0);
        req = 2'b00;
        tick();
        chk("drop_idle", 32'(gnt), 0);
        // rd_en beats drop; drop follows a cycle later
        req = 2'b01; rd_en = 1;
        tick();
        chk("def_nodrop", 32'(drop_pulse), 0);
        chk("def_head", 32'(rd_slot), 13);
        rd_en = 0;
        tick();
        chk("def_drop", 32'(drop_pulse), 1);
        chk("def_head2", 32'(rd_slot), 12);
        tick();
        chk("def_gnt", 32'(gnt), 1);
        chk("def_gnt_slot", 32'(gnt_slot), 13);
        // asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_rd_vld", 32'(rd_vld), 0);
        chk("arst_free", 32'(free_cnt), 16);
        tick();
        chk("arst2_gnt", 32'(gnt), 0);
        chk("arst2_rd_vld", 32'(rd_vld), 0);
        rst = 1'b0; req = 2'b00;
        tick();
        chk("post_drop", 32'(drop_pulse), 0);
        chk("post_err", 32'(err_pulse), 0);
        chk("post_gnt", 32'(gnt), 0);
        chk("post_free", 32'(free_cnt), 16);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_slot_scheduler.md
FRAME_SLOT_SCHEDULER -- requirements
Module: frame_slot_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 16: number of frame-buffer slots managed; slot index width SLOT_W = 4.
REQ-002 Parameter DROP_OLDEST, default 1: when 1, a starved request reclaims the oldest READY slot.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  2  per-producer slot request, level, held until granted.
REQ-006 gnt  out  2  one-hot, one-cycle grant pulse.
REQ-007 gnt_slot  out  4  slot index, valid while gnt != 0.
REQ-008 commit_en  in  1  producer finished writing commit_slot.
REQ-009 commit_slot  in  4  slot being committed.
REQ-010 rd_vld  out  1  READY queue non-empty; rd_slot valid (prefetch style).
REQ-011 rd_slot  out  4  oldest READY slot.
REQ-012 rd_en  in  1  consumer takes rd_slot; ignored when rd_vld = 0.
REQ-013 release_en  in  1  consumer finished reading release_slot.
REQ-014 release_slot  in  4  slot returned to pool.
REQ-015 free_cnt  out  5  number of FREE slots.
REQ-016 drop_pulse  out  1  one-cycle pulse per reclaimed READY slot.
REQ-017 err_pulse  out  1  one-cycle pulse on an illegal commit or release.

Function
REQ-018 Each slot SHALL hold one state: FREE, WRITING, READY or READING.
  - FREE->WRITING on grant.
  - WRITING->READY on commit.
  - READY->READING on rd_en.
  - READING->FREE on release.
  - READY->FREE on drop.
REQ-019 Grant SHALL be registered: with req sampled high at cycle N and a FREE slot at N, gnt pulses at N+1 with the lowest-index FREE slot.
REQ-020 At most one grant per cycle; round-robin between req[0] and req[1]; priority pointer moves past the granted requester.
REQ-021 No requester SHALL be granted in two consecutive cycles; a requester still asserting req two cycles after gnt receives another slot.
REQ-022 The READY queue SHALL be FIFO ordered by commit; rd_slot updates the cycle after rd_en or after a commit into an empty queue.
REQ-023 Drop rule, when DROP_OLDEST = 1: req pending, zero FREE slots and READY count >= 2 ⇒ pop queue head, set that slot FREE, pulse drop_pulse; the grant follows one cycle later.
REQ-024 When DROP_OLDEST = 0, or READY count < 2, a starved request SHALL wait.
REQ-025 rd_en and drop in the same cycle: rd_en wins, drop deferred one cycle.
REQ-026 A slot released or dropped at cycle N SHALL be grant-eligible from N+1, not at N.
REQ-027 commit to a non-WRITING slot, or release of a non-READING slot ⇒ err_pulse, no state change.
REQ-028 Commit and release in the same cycle SHALL both take effect.
REQ-029 free_cnt SHALL reflect the registered slot states (one-cycle lag).

Reset
REQ-030 On rst: all slots FREE, queue empty, RR pointer at requester 0.
REQ-031 On rst: gnt = 0, gnt_slot = 0, rd_vld = 0, rd_slot = 0, free_cnt = 16, drop_pulse = 0, err_pulse = 0.
REQ-032 rst mid-operation SHALL discard all grants and queued slots immediately; no pulses on release of rst.

Structure
REQ-033 Shared package frame_slot_pkg SHALL hold NUM_SLOTS, SLOT_W and the slot-state encoding (FREE = 0, WRITING = 1, READY = 2, READING = 3).
REQ-034 The READY queue SHALL be one sub-module slot_ready_fifo: 16 x 4-bit, prefetch output, count output; it cannot overflow by construction.

Verification
REQ-035 Reset, then req = 2'b01 → gnt = 2'b01, gnt_slot = 0 one cycle later; free_cnt = 15 the following cycle.
REQ-036 req = 2'b11 held → grants alternate 01, 10, 01 with slots 0, 1, 2 and at least one idle cycle per requester.
REQ-037 Commit slots 3, 1, 2 in order → rd_slot sequence 3, 1, 2 via rd_en; release each → free_cnt returns to 16.
REQ-038 All 16 slots READY, req[0] = 1 → drop_pulse once, then gnt with slot equal to the oldest committed slot; READY count = 15.
REQ-039 Release of a FREE slot 5 → err_pulse = 1 for one cycle, free_cnt unchanged.
REQ-040 Assert rst while gnt is pending and 4 slots are READY → next cycle rd_vld = 0, free_cnt = 16, no gnt.
